// File: rtl/mcu_mem_bridge.sv
// mcu_mem_bridge: memory-side slave of the MCU bus.
// Decodes each request to on-chip RAM, OTP or unmapped space.
// Sequences the macro strobes and returns a one-cycle mem_ack.
// The output registers (ram_a/ram_d/otp_a) double as the latched request copies.
module mcu_mem_bridge #(
  parameter int          RAM_AW    = 11,
  parameter logic [15:0] OTP_BASE  = 16'h8000,
  parameter logic [7:0]  UNMAP_DAT = 8'hFF
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [15:0]       mem_addr,
  input  logic [7:0]        mem_wdat,
  output logic [7:0]        mem_rdat,
  output logic              mem_ack,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_d,
  input  logic [7:0]        ram_q,
  output logic              otp_ce,
  output logic [15:0]       otp_a,
  input  logic [7:0]        otp_q,
  input  logic [3:0]        otp_wait,
  output logic              err_wp,
  input  logic              err_clr
);

  typedef enum logic [2:0] {IDLE, RAM, OTP, ACK, HOLD} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       req;
  logic       is_wr;
  logic       hit_ram;
  logic       hit_otp;
  logic       err_set;

  // Request decode. A simultaneous read+write is served as a write.
  always_comb begin
    req     = mem_r | mem_w;
    is_wr   = mem_w;
    hit_ram = (mem_addr >> RAM_AW) == 16'd0;
    hit_otp = mem_addr >= OTP_BASE;
    err_set = (state == IDLE) && req &&
              ((mem_r && mem_w) || (is_wr && !hit_ram));
  end

  // Main sequencer. The state, strobes, ack and read data are all registered here.
  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      mem_rdat <= 8'd0;
      mem_ack  <= 1'b0;
      ram_ce   <= 1'b0;
      ram_we   <= 1'b0;
      ram_a    <= '0;
      ram_d    <= 8'd0;
      otp_ce   <= 1'b0;
      otp_a    <= 16'd0;
    end else begin
      mem_ack <= 1'b0;
      ram_ce  <= 1'b0;
      ram_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (hit_ram) begin
              state  <= RAM;
              ram_ce <= 1'b1;
              ram_we <= is_wr;
              ram_a  <= mem_addr[RAM_AW-1:0];
              ram_d  <= mem_wdat;
            end else if (hit_otp && !is_wr) begin
              state    <= OTP;
              otp_ce   <= 1'b1;
              otp_a    <= mem_addr - OTP_BASE;
              wait_cnt <= otp_wait;
            end else begin
              if (!is_wr) begin
                mem_rdat <= UNMAP_DAT;
              end
              state   <= ACK;
              mem_ack <= 1'b1;
            end
          end
        end
        RAM: begin
          if (!ram_we) begin
            mem_rdat <= ram_q;
          end
          state   <= ACK;
          mem_ack <= 1'b1;
        end
        OTP: begin
          if (wait_cnt == 4'd0) begin
            otp_ce   <= 1'b0;
            mem_rdat <= otp_q;
            state    <= ACK;
            mem_ack  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK:     state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky write-protect error flag. A new error wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      err_wp <= 1'b0;
    end else if (err_set) begin
      err_wp <= 1'b1;
    end else if (err_clr) begin
      err_wp <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcu_mem_bridge.sv
// tb_mcu_mem_bridge: directed testbench for mcu_mem_bridge with behavioural RAM/OTP macros.
module tb_mcu_mem_bridge;

  logic        clk = 1'b0;
  logic        srst;
  logic        mem_r, mem_w;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdat;
  logic [7:0]  mem_rdat;
  logic        mem_ack;
  logic        ram_ce, ram_we;
  logic [10:0] ram_a;
  logic [7:0]  ram_d, ram_q;
  logic        otp_ce;
  logic [15:0] otp_a;
  logic [7:0]  otp_q;
  logic [3:0]  otp_wait;
  logic        err_wp, err_clr;

  logic [7:0] ramModel [0:2047];
  int ramCeCycles = 0, ramWrCycles = 0, otpCeCycles = 0, ackCycles = 0;
  int vectors = 0, miscompares = 0;

  mcu_mem_bridge dut (
    .clk(clk), .srst(srst), .mem_r(mem_r), .mem_w(mem_w),
    .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat), .mem_ack(mem_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q),
    .otp_ce(otp_ce), .otp_a(otp_a), .otp_q(otp_q), .otp_wait(otp_wait),
    .err_wp(err_wp), .err_clr(err_clr)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read of the addressed byte
  assign ram_q = ramModel[ram_a];

  // RAM write port and strobe/ack activity counters
  always @(posedge clk) begin
    if (ram_ce && ram_we) ramModel[ram_a] <= ram_d;
    if (ram_ce) ramCeCycles++;
    if (ram_ce && ram_we) ramWrCycles++;
    if (otp_ce) otpCeCycles++;
    if (mem_ack) ackCycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One bus transaction; lat = negedges after the accept edge until mem_ack is seen high
  task automatic applyStimulus(input logic r, input logic w, input logic [15:0] addr,
                               input logic [7:0] wdat, input logic [3:0] wt,
                               input logic trail, output int lat);
    @(negedge clk);
    mem_r = r; mem_w = w; mem_addr = addr; mem_wdat = wdat; otp_wait = wt;
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_ack) break;
    end
    mem_r = 1'b0;
    if (!trail) mem_w = 1'b0;
    mem_addr = 16'h7777; mem_wdat = 8'h00;
    @(negedge clk);
    mem_w = 1'b0;
  endtask

  int lat, ceSnap, wrSnap, otpSnap, ackSnap;

  initial begin
    srst = 1'b1; mem_r = 0; mem_w = 0; mem_addr = 0; mem_wdat = 0;
    otp_q = 8'h00; otp_wait = 0; err_clr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ack",  mem_ack,  0);
    checkOutput("reset_rdat", mem_rdat, 0);
    checkOutput("reset_err",  err_wp,   0);
    checkOutput("reset_ce",   {ram_ce, ram_we, otp_ce}, 0);
    srst = 1'b0;

    // RAM write then read back
    ceSnap = ramCeCycles; wrSnap = ramWrCycles;
    applyStimulus(0, 1, 16'h0123, 8'hA5, 0, 0, lat);
    checkOutput("ramwr_lat",   lat, 2);
    checkOutput("ramwr_pulse", ramWrCycles - wrSnap, 1);
    checkOutput("ramwr_addr",  ram_a, 11'h123);
    checkOutput("ramwr_data",  ramModel[11'h123], 8'hA5);
    checkOutput("ramwr_rdat",  mem_rdat, 0);
    ceSnap = ramCeCycles; wrSnap = ramWrCycles;
    applyStimulus(1, 0, 16'h0123, 8'h00, 0, 0, lat);
    checkOutput("ramrd_lat",  lat, 2);
    checkOutput("ramrd_rdat", mem_rdat, 8'hA5);
    checkOutput("ramrd_ce",   ramCeCycles - ceSnap, 1);
    checkOutput("ramrd_we",   ramWrCycles - wrSnap, 0);

    // OTP reads with 3 and 0 extra wait cycles
    otp_q = 8'h3C; otpSnap = otpCeCycles;
    applyStimulus(1, 0, 16'h8010, 8'h00, 4'd3, 0, lat);
    checkOutput("otp3_lat",  lat, 5);
    checkOutput("otp3_ce",   otpCeCycles - otpSnap, 4);
    checkOutput("otp3_addr", otp_a, 16'h0010);
    checkOutput("otp3_rdat", mem_rdat, 8'h3C);
    otp_q = 8'hC3; otpSnap = otpCeCycles;
    applyStimulus(1, 0, 16'h8001, 8'h00, 4'd0, 0, lat);
    checkOutput("otp0_lat",  lat, 2);
    checkOutput("otp0_ce",   otpCeCycles - otpSnap, 1);
    checkOutput("otp0_rdat", mem_rdat, 8'hC3);

    // OTP write: no strobe, error, rdat untouched
    ceSnap = ramCeCycles; otpSnap = otpCeCycles;
    applyStimulus(0, 1, 16'h8000, 8'h99, 0, 0, lat);
    checkOutput("otpwr_lat",    lat, 1);
    checkOutput("otpwr_strobe", (ramCeCycles - ceSnap) + (otpCeCycles - otpSnap), 0);
    checkOutput("otpwr_err",    err_wp, 1);
    checkOutput("otpwr_rdat",   mem_rdat, 8'hC3);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    checkOutput("errclr", err_wp, 0);

    // Unmapped read and write
    ceSnap = ramCeCycles; otpSnap = otpCeCycles;
    applyStimulus(1, 0, 16'h4000, 8'h00, 0, 0, lat);
    checkOutput("unrd_lat",    lat, 1);
    checkOutput("unrd_rdat",   mem_rdat, 8'hFF);
    checkOutput("unrd_err",    err_wp, 0);
    checkOutput("unrd_strobe", (ramCeCycles - ceSnap) + (otpCeCycles - otpSnap), 0);
    applyStimulus(0, 1, 16'h4000, 8'h12, 0, 0, lat);
    checkOutput("unwr_lat",  lat, 1);
    checkOutput("unwr_err",  err_wp, 1);
    checkOutput("unwr_rdat", mem_rdat, 8'hFF);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    checkOutput("errclr2", err_wp, 0);

    // Back-to-back writes with mem_w trailing one cycle past ack
    wrSnap = ramWrCycles; ackSnap = ackCycles;
    applyStimulus(0, 1, 16'h0010, 8'h11, 0, 1, lat);
    applyStimulus(0, 1, 16'h0011, 8'h22, 0, 1, lat);
    repeat (3) @(negedge clk);
    checkOutput("b2b_writes", ramWrCycles - wrSnap, 2);
    checkOutput("b2b_acks",   ackCycles - ackSnap, 2);
    checkOutput("b2b_d10",    ramModel[11'h010], 8'h11);
    checkOutput("b2b_d11",    ramModel[11'h011], 8'h22);
    applyStimulus(1, 0, 16'h0011, 8'h00, 0, 0, lat);
    checkOutput("b2b_rd", mem_rdat, 8'h22);

    // Simultaneous read and write: served as write, flags error
    wrSnap = ramWrCycles;
    applyStimulus(1, 1, 16'h0040, 8'h5A, 0, 0, lat);
    checkOutput("rw_lat",    lat, 2);
    checkOutput("rw_writes", ramWrCycles - wrSnap, 1);
    checkOutput("rw_data",   ramModel[11'h040], 8'h5A);
    checkOutput("rw_err",    err_wp, 1);
    checkOutput("rw_rdat",   mem_rdat, 8'h22);

    // Reset in the middle of a long OTP wait
    @(negedge clk);
    mem_r = 1; mem_addr = 16'h8005; otp_wait = 4'd15;
    @(posedge clk);
    repeat (3) @(negedge clk);
    checkOutput("rst_otp_busy", otp_ce, 1);
    srst = 1; mem_r = 0;
    @(posedge clk); #1;
    checkOutput("rst_otp_ce", otp_ce, 0);
    checkOutput("rst_err",    err_wp, 0);
    @(negedge clk); srst = 0;
    ackSnap = ackCycles;
    repeat (20) @(negedge clk);
    checkOutput("rst_noack", ackCycles - ackSnap, 0);
    applyStimulus(1, 0, 16'h0123, 8'h00, 0, 0, lat);
    checkOutput("rst_ramrd_lat",  lat, 2);
    checkOutput("rst_ramrd_rdat", mem_rdat, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
